// File: rtl/execute_pipe_stage_pkg.sv
// Shared types and defaults for the execute pipeline stage.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package execute_pipe_stage_pkg;

  localparam int XLEN_DEF       = 32;
  localparam int MUL_CYCLES_DEF = 4;
  localparam int CTRL_W_DEF     = 5;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SLL   = 4'b0001,
    ALU_SLT   = 4'b0010,
    ALU_SLTU  = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SRL   = 4'b0101,
    ALU_OR    = 4'b0110,
    ALU_AND   = 4'b0111,
    ALU_SUB   = 4'b1000,
    ALU_COPYB = 4'b1001,
    ALU_SRA   = 4'b1101
  } alu_fun_e;

  typedef enum logic [3:0] {
    BR_NONE = 4'd0,
    BR_BEQ  = 4'd1,
    BR_BNE  = 4'd2,
    BR_BLT  = 4'd3,
    BR_BGE  = 4'd4,
    BR_BLTU = 4'd5,
    BR_BGEU = 4'd6,
    BR_JAL  = 4'd7,
    BR_JALR = 4'd8
  } br_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/exec_mul_iter.sv
// Iterative shift-add multiplier, low XLEN bits of i_a*i_b.
// Latency: MUL_CYCLES-1 cycles from i_start to o_done; o_done stays high until next start.
// Backpressure: none; result is held until the next i_start. Ports: i_core_clk, i_arst_n, i_start, i_a, i_b -> o_done, o_product.
module exec_mul_iter
  import execute_pipe_stage_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int MUL_CYCLES = MUL_CYCLES_DEF
) (
  input  logic            i_core_clk,
  input  logic            i_arst_n,
  input  logic            i_start,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_done,
  output logic [XLEN-1:0] o_product
);

  // The multiplier bits are consumed CHUNK at a time so the product is
  // complete after STEPS edges, one edge before the owner wants it.
  localparam int STEPS = MUL_CYCLES - 1;
  localparam int CHUNK = (XLEN + STEPS - 1) / STEPS;
  localparam int SC_W  = (STEPS > 1) ? $clog2(STEPS) : 1;

  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_acc;
  logic [SC_W-1:0] r_step;
  logic            r_busy;
  logic            r_done;
  logic [XLEN-1:0] w_part;

  always_comb begin
    w_part = r_acc;
    for (int j = 0; j < CHUNK; j++) begin
      if (r_b[j]) w_part = w_part + (r_a << j);
    end
  end

  always_ff @(posedge i_core_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_acc  <= '0;
      r_step <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else if (i_start) begin
      r_a    <= i_a;
      r_b    <= i_b;
      r_acc  <= '0;
      r_step <= '0;
      r_busy <= 1'b1;
      r_done <= 1'b0;
    end else if (r_busy) begin
      r_acc  <= w_part;
      r_a    <= r_a << CHUNK;
      r_b    <= r_b >> CHUNK;
      r_step <= r_step + 1'b1;
      if (r_step == SC_W'(STEPS - 1)) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
    end
  end

  assign o_done    = r_done;
  assign o_product = r_acc;

endmodule

// File: rtl/execute_pipe_stage.sv
// Execute stage: ALU, branch resolution and iterative multiply into one output register.
// Latency: 1 cycle for ALU/branch ops, MUL_CYCLES cycles for multiplies; redirect pulse the cycle after transfer.
// Backpressure: valid/ready; DR_READY low while multiplying or while the held result is not taken by MEM_READY.
// Ports: EXECUTE_CLOCK/EXECUTE_RESET; DR_* decode inputs with DR_VALID/DR_READY;
//        MEM_READY; EX_* registered results; FLUSH_OUT/TARGET_PC redirect.
module execute_pipe_stage
  import execute_pipe_stage_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int CTRL_W     = CTRL_W_DEF
) (
  input  logic              EXECUTE_CLOCK,
  input  logic              EXECUTE_RESET,
  input  logic              DR_VALID,
  output logic              DR_READY,
  input  logic [XLEN-1:0]   DR_PC,
  input  logic [XLEN-1:0]   DR_PC_4,
  input  logic [XLEN-1:0]   DR_RS1,
  input  logic [XLEN-1:0]   DR_RS2,
  input  logic [XLEN-1:0]   DR_OPB,
  input  logic [XLEN-1:0]   DR_IMM_I,
  input  logic [XLEN-1:0]   DR_IMM_B,
  input  logic [XLEN-1:0]   DR_IMM_J,
  input  logic [3:0]        DR_ALU_FUN,
  input  logic              DR_IS_MUL,
  input  logic [3:0]        DR_BR_TYPE,
  input  logic [CTRL_W-1:0] DR_CTRL,
  input  logic              MEM_READY,
  output logic              EX_VALID,
  output logic [XLEN-1:0]   EX_PC_4,
  output logic [XLEN-1:0]   EX_ALU_RESULT,
  output logic [XLEN-1:0]   EX_RS2,
  output logic [CTRL_W-1:0] EX_CTRL,
  output logic              FLUSH_OUT,
  output logic [XLEN-1:0]   TARGET_PC
);

  localparam int SH_W  = $clog2(XLEN);
  localparam int CNT_W = $clog2(MUL_CYCLES);

  state_e            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ex_valid;
  logic [XLEN-1:0]   r_ex_pc_4;
  logic [XLEN-1:0]   r_ex_alu;
  logic [XLEN-1:0]   r_ex_rs2;
  logic [CTRL_W-1:0] r_ex_ctrl;
  logic              r_flush;
  logic [XLEN-1:0]   r_target;
  // Side-band of an in-flight multiply, written to the output register in DONE.
  logic [XLEN-1:0]   r_mul_pc_4;
  logic [XLEN-1:0]   r_mul_rs2;
  logic [CTRL_W-1:0] r_mul_ctrl;

  logic              w_fire;
  logic              w_fire_alu;
  logic              w_fire_mul;
  logic [SH_W-1:0]   w_shamt;
  logic [XLEN-1:0]   w_alu;
  logic              w_taken;
  logic [XLEN-1:0]   w_target;
  logic [XLEN-1:0]   w_jalr_sum;
  logic              w_mul_done;
  logic [XLEN-1:0]   w_mul_prod;

  assign DR_READY   = (r_state == ST_IDLE) && (!r_ex_valid || MEM_READY);
  assign w_fire     = DR_VALID && DR_READY;
  // A multiply wins over any branch kind presented with it.
  assign w_fire_mul = w_fire && DR_IS_MUL;
  assign w_fire_alu = w_fire && !DR_IS_MUL;
  assign w_shamt    = DR_OPB[SH_W-1:0];
  assign w_jalr_sum = DR_RS1 + DR_IMM_I;

  always_comb begin
    w_alu = '0;
    case (alu_fun_e'(DR_ALU_FUN))
      ALU_ADD:   w_alu = DR_RS1 + DR_OPB;
      ALU_SUB:   w_alu = DR_RS1 - DR_OPB;
      ALU_SLL:   w_alu = DR_RS1 << w_shamt;
      ALU_SLT:   w_alu = {{(XLEN-1){1'b0}}, ($signed(DR_RS1) < $signed(DR_OPB))};
      ALU_SLTU:  w_alu = {{(XLEN-1){1'b0}}, (DR_RS1 < DR_OPB)};
      ALU_XOR:   w_alu = DR_RS1 ^ DR_OPB;
      ALU_SRL:   w_alu = DR_RS1 >> w_shamt;
      ALU_SRA:   w_alu = $unsigned($signed(DR_RS1) >>> w_shamt);
      ALU_OR:    w_alu = DR_RS1 | DR_OPB;
      ALU_AND:   w_alu = DR_RS1 & DR_OPB;
      ALU_COPYB: w_alu = DR_OPB;
      default:   w_alu = '0;
    endcase
  end

  always_comb begin
    w_taken  = 1'b0;
    w_target = DR_PC + DR_IMM_B;
    case (br_type_e'(DR_BR_TYPE))
      BR_BEQ:  w_taken = (DR_RS1 == DR_RS2);
      BR_BNE:  w_taken = (DR_RS1 != DR_RS2);
      BR_BLT:  w_taken = ($signed(DR_RS1) <  $signed(DR_RS2));
      BR_BGE:  w_taken = ($signed(DR_RS1) >= $signed(DR_RS2));
      BR_BLTU: w_taken = (DR_RS1 <  DR_RS2);
      BR_BGEU: w_taken = (DR_RS1 >= DR_RS2);
      BR_JAL: begin
        w_taken  = 1'b1;
        w_target = DR_PC + DR_IMM_J;
      end
      BR_JALR: begin
        w_taken  = 1'b1;
        w_target = {w_jalr_sum[XLEN-1:1], 1'b0};
      end
      default: w_taken = 1'b0;
    endcase
  end

  exec_mul_iter #(
    .XLEN       (XLEN),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul (
    .i_core_clk (EXECUTE_CLOCK),
    .i_arst_n   (EXECUTE_RESET),
    .i_start    (w_fire_mul),
    .i_a        (DR_RS1),
    .i_b        (DR_OPB),
    .o_done     (w_mul_done),
    .o_product  (w_mul_prod)
  );

  // Entry to DONE waits for the output register to be free, so the
  // DONE-cycle load never overwrites an unconsumed result.
  always_ff @(posedge EXECUTE_CLOCK or negedge EXECUTE_RESET) begin
    if (!EXECUTE_RESET) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_fire_mul) begin
            r_state <= ST_MUL;
            r_cnt   <= CNT_W'(MUL_CYCLES - 2);
          end
        end
        ST_MUL: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (!r_ex_valid || MEM_READY) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (w_mul_done) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge EXECUTE_CLOCK or negedge EXECUTE_RESET) begin
    if (!EXECUTE_RESET) begin
      r_ex_valid <= 1'b0;
      r_ex_pc_4  <= '0;
      r_ex_alu   <= '0;
      r_ex_rs2   <= '0;
      r_ex_ctrl  <= '0;
      r_flush    <= 1'b0;
      r_target   <= '0;
      r_mul_pc_4 <= '0;
      r_mul_rs2  <= '0;
      r_mul_ctrl <= '0;
    end else begin
      if (w_fire_alu) begin
        r_ex_valid <= 1'b1;
        r_ex_pc_4  <= DR_PC_4;
        r_ex_alu   <= w_alu;
        r_ex_rs2   <= DR_RS2;
        r_ex_ctrl  <= DR_CTRL;
      end else if ((r_state == ST_DONE) && w_mul_done) begin
        r_ex_valid <= 1'b1;
        r_ex_pc_4  <= r_mul_pc_4;
        r_ex_alu   <= w_mul_prod;
        r_ex_rs2   <= r_mul_rs2;
        r_ex_ctrl  <= r_mul_ctrl;
      end else if (MEM_READY) begin
        r_ex_valid <= 1'b0;
      end

      if (w_fire_mul) begin
        r_mul_pc_4 <= DR_PC_4;
        r_mul_rs2  <= DR_RS2;
        r_mul_ctrl <= DR_CTRL;
      end

      r_flush <= w_fire_alu && w_taken;
      if (w_fire_alu && w_taken) r_target <= w_target;
    end
  end

  assign EX_VALID      = r_ex_valid;
  assign EX_PC_4       = r_ex_pc_4;
  assign EX_ALU_RESULT = r_ex_alu;
  assign EX_RS2        = r_ex_rs2;
  assign EX_CTRL       = r_ex_ctrl;
  assign FLUSH_OUT     = r_flush;
  assign TARGET_PC     = r_target;

endmodule
